// File: rtl/mux_nt1_scan_pkg.sv
// Shared encodings for the N:1 display channel selector: mode input values
// and the selector FSM states.
package mux_nt1_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_AUTO   = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/mux_nt1_scan_dwell_timer.sv
// Dwell counter for auto-scan: counts enabled cycles and flags the last
// cycle of each dwell period, wrapping to zero on that cycle.
module dwell_timer #(
    parameter int DWELL = 50000000,
    parameter int CNT_W = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] count;

    assign tc = (count == LAST_CNT);

    // clear beats enable; with neither asserted the count is frozen
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            if (tc) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nt1_scan.sv
// Parametrised N:1 channel selector for the IO display path with manual
// select, timed auto-scan and hold, driving a registered output word.
module mux_nt1_scan
    import mux_nt1_scan_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          o,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      switch_pulse
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);

    state_t           st;
    state_t           st_nxt;
    logic             auto_act;
    logic             man_act;
    logic             tc;
    logic [SEL_W-1:0] cur_sel_nxt;
    logic [WIDTH-1:0] sel_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= ST_MANUAL;
        end else begin
            st <= st_nxt;
        end
    end

    // Releasing hold acts on the mode input at once, so a frozen dwell
    // resumes (or manual select applies) on the first cycle after release.
    always_comb begin
        st_nxt   = st;
        auto_act = 1'b0;
        man_act  = 1'b0;
        if (hold) begin
            st_nxt = ST_HOLD;
        end else begin
            case (st)
                ST_MANUAL: begin
                    man_act = 1'b1;
                    if (mode == MODE_AUTO) st_nxt = ST_AUTO;
                end
                ST_AUTO: begin
                    auto_act = 1'b1;
                    if (mode == MODE_MANUAL) st_nxt = ST_MANUAL;
                end
                ST_HOLD: begin
                    auto_act = (mode == MODE_AUTO);
                    man_act  = (mode == MODE_MANUAL);
                    st_nxt   = (mode == MODE_AUTO) ? ST_AUTO : ST_MANUAL;
                end
                default: begin
                    st_nxt = ST_MANUAL;
                end
            endcase
        end
    end

    dwell_timer #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (auto_act),
        .clr (man_act),
        .tc  (tc)
    );

    // cur_sel_nxt is always a valid channel: bad manual codes are dropped
    // and the scan wraps at the last real channel.
    always_comb begin
        cur_sel_nxt = cur_sel;
        if (man_act && (sel_in <= LAST_SEL)) begin
            cur_sel_nxt = sel_in;
        end else if (auto_act && tc) begin
            cur_sel_nxt = (cur_sel == LAST_SEL) ? '0 : cur_sel + 1'b1;
        end
    end

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cur_sel_nxt == SEL_W'(k)) begin
                sel_word = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            o            <= '0;
            cur_sel      <= '0;
            switch_pulse <= 1'b0;
        end else if (hold) begin
            switch_pulse <= 1'b0;
        end else begin
            o            <= sel_word;
            cur_sel      <= cur_sel_nxt;
            switch_pulse <= auto_act && tc;
        end
    end

endmodule

// File: tb/tb_mux_nt1_scan.sv
// Bench for mux_nt1_scan: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the selector kept in the bench.
module tb_mux_nt1_scan;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 3;
    localparam int SEL_W    = 2;
    localparam int DWELL    = 4;
    localparam int CNT_W    = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]          sel_in;
    logic                      mode;
    logic                      hold;
    logic [WIDTH-1:0]          o;
    logic [SEL_W-1:0]          cur_sel;
    logic                      switch_pulse;

    logic [WIDTH-1:0] ch [CHANNELS];

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model: what is shown, how long it has been shown in auto
    // mode, and whether the block is scanning or just came out of a hold
    logic [WIDTH-1:0] m_o;
    int               m_sel;
    logic             m_pulse;
    bit               m_auto;
    bit               m_held;
    int               m_age;

    assign data_in = {ch[2], ch[1], ch[0]};

    always #5 clk = ~clk;

    mux_nt1_scan #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W),
        .DWELL    (DWELL),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .sel_in       (sel_in),
        .mode         (mode),
        .hold         (hold),
        .o            (o),
        .cur_sel      (cur_sel),
        .switch_pulse (switch_pulse)
    );

    task automatic model_edge();
        bit scanning;
        if (rst) begin
            m_o = '0; m_sel = 0; m_pulse = 1'b0;
            m_auto = 1'b0; m_held = 1'b0; m_age = 0;
        end else if (hold) begin
            m_pulse = 1'b0;
            m_held  = 1'b1;
        end else begin
            scanning = m_held ? mode : m_auto;
            m_pulse  = 1'b0;
            if (scanning) begin
                m_age++;
                if (m_age == DWELL) begin
                    m_age   = 0;
                    m_sel   = (m_sel + 1) % CHANNELS;
                    m_pulse = 1'b1;
                end
            end else begin
                m_age = 0;
                if (int'(sel_in) < CHANNELS) m_sel = int'(sel_in);
            end
            m_o    = ch[m_sel];
            m_auto = mode;
            m_held = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sel_in = SEL_W'($urandom_range(0, 3));
            mode   = 1'($urandom_range(0, 1));
            hold   = 1'($urandom_range(0, 1));
            tick();
        end
        n_tests++;
        if (o !== 8'h00 || cur_sel !== 2'd0 || switch_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: o=%h sel=%0d pulse=%b, want o=00 sel=0 pulse=0", o, cur_sel, switch_pulse);
        end
        rst = 1'b0; mode = 1'b0; hold = 1'b0; sel_in = 2'd0;
        tick();
        n_tests++;
        if (o !== 8'hA0) begin
            n_fail++;
            $display("FAIL reset_release: o=%h want A0", o);
        end
    endtask

    task automatic test_manual();
        logic [WIDTH-1:0] exp_o   [3] = '{8'hB1, 8'hC2, 8'hC2};
        logic [SEL_W-1:0] exp_sel [3] = '{2'd1, 2'd2, 2'd2};
        for (int i = 0; i < 3; i++) begin
            sel_in = SEL_W'(i + 1);
            tick();
            n_tests++;
            if (o !== exp_o[i] || cur_sel !== exp_sel[i]) begin
                n_fail++;
                $display("FAIL manual_sel%0d: o=%h sel=%0d, want o=%h sel=%0d", i + 1, o, cur_sel, exp_o[i], exp_sel[i]);
            end
        end
    endtask

    task automatic test_auto_scan();
        logic [WIDTH-1:0] exp_o   [3] = '{8'hB1, 8'hC2, 8'hA0};
        logic [SEL_W-1:0] exp_sel [3] = '{2'd1, 2'd2, 2'd0};
        sel_in = 2'd0;
        tick();
        mode   = 1'b1;
        sel_in = 2'd3;
        tick();
        for (int a = 0; a < 3; a++) begin
            for (int t = 0; t < DWELL; t++) begin
                sel_in = SEL_W'($urandom_range(0, 3));
                tick();
                n_tests++;
                if (switch_pulse !== (t == DWELL - 1)) begin
                    n_fail++;
                    $display("FAIL auto_pulse adv%0d cyc%0d: pulse=%b want %b", a, t, switch_pulse, (t == DWELL - 1));
                end
            end
            n_tests++;
            if (o !== exp_o[a] || cur_sel !== exp_sel[a]) begin
                n_fail++;
                $display("FAIL auto_adv%0d: o=%h sel=%0d, want o=%h sel=%0d", a, o, cur_sel, exp_o[a], exp_sel[a]);
            end
        end
    endtask

    task automatic test_hold();
        tick();
        tick();
        hold = 1'b1;
        mode = 1'($urandom_range(0, 1));
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (o !== 8'hA0 || cur_sel !== 2'd0 || switch_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cyc%0d: o=%h sel=%0d pulse=%b, want A0/0/0", i, o, cur_sel, switch_pulse);
            end
        end
        hold = 1'b0;
        mode = 1'b1;
        tick();
        n_tests++;
        if (switch_pulse !== 1'b0 || cur_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL hold_release1: sel=%0d pulse=%b, want 0/0", cur_sel, switch_pulse);
        end
        tick();
        n_tests++;
        if (switch_pulse !== 1'b1 || cur_sel !== 2'd1 || o !== 8'hB1) begin
            n_fail++;
            $display("FAIL hold_release2: o=%h sel=%0d pulse=%b, want B1/1/1", o, cur_sel, switch_pulse);
        end
    endtask

    task automatic test_reset_mid_scan();
        for (int t = 0; t < DWELL; t++) tick();
        n_tests++;
        if (cur_sel !== 2'd2) begin
            n_fail++;
            $display("FAIL midscan_pre: sel=%0d want 2", cur_sel);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (cur_sel !== 2'd0 || o !== 8'h00 || switch_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL midscan_reset: o=%h sel=%0d pulse=%b, want 00/0/0", o, cur_sel, switch_pulse);
        end
        rst    = 1'b0;
        sel_in = 2'd0;
        tick();
        for (int t = 0; t < DWELL; t++) begin
            tick();
            n_tests++;
            if (switch_pulse !== (t == DWELL - 1)) begin
                n_fail++;
                $display("FAIL midscan_restart cyc%0d: pulse=%b want %b", t, switch_pulse, (t == DWELL - 1));
            end
        end
        n_tests++;
        if (cur_sel !== 2'd1 || o !== 8'hB1) begin
            n_fail++;
            $display("FAIL midscan_adv: o=%h sel=%0d, want B1/1", o, cur_sel);
        end
    endtask

    task automatic test_live_data();
        mode   = 1'b0;
        sel_in = 2'd1;
        tick();
        tick();
        n_tests++;
        if (o !== 8'hB1) begin
            n_fail++;
            $display("FAIL live_before: o=%h want B1", o);
        end
        ch[1] = 8'h5F;
        tick();
        n_tests++;
        if (o !== 8'h5F) begin
            n_fail++;
            $display("FAIL live_after: o=%h want 5F", o);
        end
        ch[1] = 8'hB1;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 49) == 0);
            hold   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 11) == 0) mode = ~mode;
            sel_in = SEL_W'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) ch[$urandom_range(0, CHANNELS - 1)] = WIDTH'($urandom);
            tick();
            n_tests++;
            if (o !== m_o || int'(cur_sel) != m_sel || switch_pulse !== m_pulse) begin
                n_fail++;
                $display("FAIL random cyc%0d: o=%h sel=%0d pulse=%b, want o=%h sel=%0d pulse=%b", i, o, cur_sel, switch_pulse, m_o, m_sel, m_pulse);
            end
        end
    endtask

    initial begin
        ch[0] = 8'hA0; ch[1] = 8'hB1; ch[2] = 8'hC2;
        rst = 1'b1; mode = 1'b0; hold = 1'b0; sel_in = 2'd0;
        m_o = '0; m_sel = 0; m_pulse = 1'b0; m_auto = 1'b0; m_held = 1'b0; m_age = 0;
        test_reset();
        test_manual();
        test_auto_scan();
        test_hold();
        test_reset_mid_scan();
        test_live_data();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
